multicycle_cpu_core: RTL
========================

// Module: multicycle_cpu_core
// PURPOSE
//  Parametrised multi-cycle accumulator CPU: fetch/decode/execute/writeback FSM, register file, ALU, branch unit.
//  Generalises data width, register count and PC width over the fixed 8-bit core.
//  Adds handshaked IN/OUT ports, AND/NOP ops, a sticky illegal-opcode flag and a halt status output.
//  Instruction memory is external, synchronous, 1-cycle read latency.
// PARAMETERS
//  DW     8  data / register width
//  RF_AW  4  register address width; 2**RF_AW registers
//  PC_W   8  program counter / imem address width
//  IW     4+3*RF_AW  instruction width {op[3:0],RA,RB,RD} (derived, do not override)
// PORTS
//  clk         in   1     clock, rising edge
//  rst         in   1     asynchronous active-high reset
//  imem_addr   out  PC_W  instruction address, = PC combinationally
//  imem_rdata  in   IW    instruction data, valid 1 cycle after imem_addr
//  in_data     in   DW    input port data
//  in_valid    in   1     input data available
//  in_ready    out  1     core accepting input (IN instruction waiting)
//  out_data    out  DW    output port data, holds last value written
//  out_valid   out  1     out_data offered (OUT instruction waiting)
//  out_ready   in   1     consumer accepts out_data
//  halted      out  1     HALT executed; sticky until rst
//  illegal     out  1     undefined opcode seen; sticky until rst
//  pc_dbg      out  PC_W  current PC, debug/testbench
// BEHAVIOUR
//  Reset (async): PC=0, IR=0, state=FETCH, out_data=0, out_valid=0, in_ready=0, halted=0, illegal=0.
//   Register file not reset. Reset mid-operation abandons instruction and any pending IN/OUT handshake.
//  States: FETCH -> DECODE -> EXEC -> {WB | IO | FETCH | HALT}; WB -> FETCH; IO -> FETCH on handshake.
//   FETCH: imem_addr=PC presented. DECODE: IR<=imem_rdata, PC<=PC+1.
//   EXEC: compute W / branch. WB: R[RD]<=W.
//  Latency: ALU/LOAD/CALL = 4 cycles; branches/NOP/illegal = 3 cycles (no WB); IN/OUT = 3 + handshake wait, >=4.
//  Opcodes (R[x] = register contents):
//   0000 NOP; 0001 LOAD  R[RD]<={RA,RB} zero-extended/truncated to DW
//   0010 AND; 0100 ADD; 0101 SUB; 0110 OR; 0111 XOR: R[RD]<=R[RA] op R[RB], mod 2**DW
//   1000 BRA   PC<=R[RB]; 1001 BRAZ if R[RA]==0 PC<=R[RB]
//   1010 BRAL  PC<=RB (zero-ext); 1011 BRALZ if R[RA]==0 PC<=RB
//   1100 CALL  R[RD]<=PC (already incremented, i.e. return addr), PC<=RB
//   1101 HALT; 1110 IN  R[RD]<=in_data; 1111 OUT  out_data<=R[RA]
//   0011 undefined: illegal<=1, treated as NOP.
//  Width rules: register->PC zero-extends or truncates to PC_W; PC->register likewise to DW.
//  Branch not taken: PC stays at PC+1.
//  PC wraps 2**PC_W-1 -> 0 silently.
//  IN: IO state drives in_ready=1. Transfer on in_valid&in_ready: write R[RD] that cycle; in_ready drops next cycle; -> FETCH.
//  OUT: EXEC loads out_data and sets out_valid=1.
//   IO holds out_data/out_valid stable until out_ready; out_valid clears on the accepting edge; -> FETCH.
//   out_data keeps its value afterwards.
//  in_valid outside IO: ignored, no data consumed. out_ready while out_valid=0: ignored.
//  HALT: halted=1 from the cycle after EXEC. FSM stays in HALT and PC frozen until rst. imem_addr held.
//  Same-register source/dest (RA==RD): reads use pre-write value; write lands in WB.
// TESTING
//  T1 LOAD R1<=0x05; LOAD R2<=0x03; ADD R3=R1+R2; OUT R3 with out_ready=1 -> out_data=0x08, out_valid one cycle, ADD takes 4 cycles.
//  T2 SUB R0=R2-R1 (3-5), DW=8 -> R0=0xFE; AND/XOR checked against model.
//  T3 BRALZ with R[RA]=0 -> PC=RB. Same with R[RA]=1 -> PC=old+1.
//   CALL RB=0x9 at PC=4 -> R[RD]=5, PC=9.
//  T4 IN with in_valid held 0 for 10 cycles -> in_ready=1 throughout, PC stalls.
//   in_valid=1 with in_data=0xA5 -> R[RD]=0xA5, in_ready drops next cycle.
//  T5 OUT with out_ready=0 for 6 cycles -> out_valid/out_data stable, no fetch. Assert rst mid-wait -> out_valid=0, PC=0.
//  T6 opcode 0011 -> illegal=1, PC advances. HALT -> halted=1, PC frozen for 20 cycles. Repeat T1 with DW=16, RF_AW=3, PC_W=10.

Source files
------------

// File: rtl/multicycle_cpu_core_if.sv
// Bus bundle for multicycle_cpu_core: instruction fetch port plus the
// handshaked IN/OUT data ports.
//   master (core side): drives imem_addr, in_ready, out_data, out_valid
//   slave  (env side) : drives imem_rdata, in_data, in_valid, out_ready
interface multicycle_cpu_core_if #(
   parameter int unsigned DW    = 8,
   parameter int unsigned RF_AW = 4,
   parameter int unsigned PC_W  = 8
) ();
   localparam int unsigned IW = 4 + 3*RF_AW;

   logic [PC_W-1:0] imem_addr;
   logic [IW-1:0]   imem_rdata;
   logic [DW-1:0]   in_data;
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   out_data;
   logic            out_valid;
   logic            out_ready;

   modport master (
      output imem_addr, in_ready, out_data, out_valid,
      input  imem_rdata, in_data, in_valid, out_ready
   );

   modport slave (
      input  imem_addr, in_ready, out_data, out_valid,
      output imem_rdata, in_data, in_valid, out_ready
   );
endinterface

// File: rtl/multicycle_cpu_core.sv
// Multi-cycle accumulator-style CPU core with register file, ALU, branch
// unit and handshaked IN/OUT ports.
// Ports:
//   clk, rst  - rising-edge clock, asynchronous active-high reset
//   bus       - multicycle_cpu_core_if.master: imem_addr/imem_rdata (sync
//               memory, 1-cycle read latency), in_data/in_valid/in_ready,
//               out_data/out_valid/out_ready
//   halted    - sticky, set once HALT executes
//   illegal   - sticky, set once opcode 0011 executes
//   pc_dbg    - current program counter
module multicycle_cpu_core #(
   parameter int unsigned DW    = 8,
   parameter int unsigned RF_AW = 4,
   parameter int unsigned PC_W  = 8,
   localparam int unsigned IW   = 4 + 3*RF_AW
) (
   input  logic                  clk,
   input  logic                  rst,
   multicycle_cpu_core_if.master bus,
   output logic                  halted,
   output logic                  illegal,
   output logic [PC_W-1:0]       pc_dbg
);

   localparam int unsigned NREG = 2**RF_AW;

   localparam logic [3:0] OP_NOP   = 4'b0000;
   localparam logic [3:0] OP_LOAD  = 4'b0001;
   localparam logic [3:0] OP_AND   = 4'b0010;
   localparam logic [3:0] OP_ILL   = 4'b0011;
   localparam logic [3:0] OP_ADD   = 4'b0100;
   localparam logic [3:0] OP_SUB   = 4'b0101;
   localparam logic [3:0] OP_OR    = 4'b0110;
   localparam logic [3:0] OP_XOR   = 4'b0111;
   localparam logic [3:0] OP_BRA   = 4'b1000;
   localparam logic [3:0] OP_BRAZ  = 4'b1001;
   localparam logic [3:0] OP_BRAL  = 4'b1010;
   localparam logic [3:0] OP_BRALZ = 4'b1011;
   localparam logic [3:0] OP_CALL  = 4'b1100;
   localparam logic [3:0] OP_HALT  = 4'b1101;
   localparam logic [3:0] OP_IN    = 4'b1110;
   localparam logic [3:0] OP_OUT   = 4'b1111;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_WB     = 3'd3,
      S_IO     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t           state;
   logic [PC_W-1:0]  pc;
   logic [IW-1:0]    ir;
   logic [DW-1:0]    w_q;
   logic [DW-1:0]    rf [NREG];

   logic [3:0]       op;
   logic [RF_AW-1:0] ra, rb, rd;
   logic [DW-1:0]    rf_a, rf_b;
   logic             ra_zero;
   logic [DW-1:0]    alu_c;
   logic [PC_W-1:0]  tgt_c;
   logic             rf_we_c;
   logic [DW-1:0]    rf_wd_c;

   // Instruction fields {op, RA, RB, RD}
   assign op = ir[IW-1 -: 4];
   assign ra = ir[3*RF_AW-1 -: RF_AW];
   assign rb = ir[2*RF_AW-1 -: RF_AW];
   assign rd = ir[RF_AW-1:0];

   assign rf_a    = rf[ra];
   assign rf_b    = rf[rb];
   assign ra_zero = (rf_a == '0);

   assign bus.imem_addr = pc;
   assign pc_dbg        = pc;

   // Write-back value; CALL stores the already-incremented PC
   always_comb begin
      alu_c = '0;
      case (op)
         OP_LOAD: alu_c = DW'({ra, rb});
         OP_AND:  alu_c = rf_a & rf_b;
         OP_ADD:  alu_c = rf_a + rf_b;
         OP_SUB:  alu_c = rf_a - rf_b;
         OP_OR:   alu_c = rf_a | rf_b;
         OP_XOR:  alu_c = rf_a ^ rf_b;
         OP_CALL: alu_c = DW'(pc);
         default: alu_c = '0;
      endcase
   end

   // Branch target: register-indirect for BRA/BRAZ, RB field otherwise
   always_comb begin
      tgt_c = PC_W'(rb);
      if (op == OP_BRA || op == OP_BRAZ) begin
         tgt_c = PC_W'(rf_b);
      end
   end

   // Register file write port: WB stage, or IN transfer in the IO state
   always_comb begin
      rf_we_c = 1'b0;
      rf_wd_c = w_q;
      if (state == S_WB) begin
         rf_we_c = 1'b1;
      end else if (state == S_IO && op == OP_IN && bus.in_valid && bus.in_ready) begin
         rf_we_c = 1'b1;
         rf_wd_c = bus.in_data;
      end
   end

   // Register file is intentionally not reset
   always_ff @(posedge clk) begin
      if (rf_we_c && !rst) begin
         rf[rd] <= rf_wd_c;
      end
   end

   // Control FSM with registered status/handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_FETCH;
         pc            <= '0;
         ir            <= '0;
         w_q           <= '0;
         bus.out_data  <= '0;
         bus.out_valid <= 1'b0;
         bus.in_ready  <= 1'b0;
         halted        <= 1'b0;
         illegal       <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               state <= S_DECODE;
            end
            S_DECODE: begin
               ir    <= bus.imem_rdata;
               pc    <= pc + PC_W'(1);
               state <= S_EXEC;
            end
            S_EXEC: begin
               state <= S_FETCH;
               case (op)
                  OP_LOAD, OP_AND, OP_ADD, OP_SUB, OP_OR, OP_XOR: begin
                     w_q   <= alu_c;
                     state <= S_WB;
                  end
                  OP_CALL: begin
                     w_q   <= alu_c;
                     pc    <= tgt_c;
                     state <= S_WB;
                  end
                  OP_BRA, OP_BRAL: begin
                     pc <= tgt_c;
                  end
                  OP_BRAZ, OP_BRALZ: begin
                     if (ra_zero) begin
                        pc <= tgt_c;
                     end
                  end
                  OP_HALT: begin
                     halted <= 1'b1;
                     state  <= S_HALT;
                  end
                  OP_IN: begin
                     bus.in_ready <= 1'b1;
                     state        <= S_IO;
                  end
                  OP_OUT: begin
                     bus.out_data  <= rf_a;
                     bus.out_valid <= 1'b1;
                     state         <= S_IO;
                  end
                  OP_ILL: begin
                     illegal <= 1'b1;
                  end
                  default: begin
                     // OP_NOP
                  end
               endcase
            end
            S_WB: begin
               state <= S_FETCH;
            end
            S_IO: begin
               // Wait here until the pending transfer completes
               if (op == OP_IN) begin
                  if (bus.in_valid) begin
                     bus.in_ready <= 1'b0;
                     state        <= S_FETCH;
                  end
               end else if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  state         <= S_FETCH;
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_FETCH;
            end
         endcase
      end
   end

endmodule
